// File: rtl/rxd_pkg.sv
// rxd_pkg
//   Shared definitions for the serial word receiver:
//   - RX (bit-level) and ASM (byte-pair assembly) state encodings
//   - tick_divisor(): clocks per oversampling tick, rounded to nearest
package rxd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    ASM_HI = 1'b0,
    ASM_LO = 1'b1
  } asm_state_t;

  // round(clk_freq / (baud * oversample)), never below 1
  function automatic int tick_divisor(input int clk_freq, input int baud, input int oversample);
    int rate;
    int div;
    rate = baud * oversample;
    div  = (clk_freq + rate / 2) / rate;
    if (div < 1) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1 oversampling receiver: 2-flop input synchroniser, free-running
//   oversample tick generator and the RX bit FSM.
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_sdi           serial input, idle high, asynchronous to i_clk
//   o_byte_valid    1-cycle pulse: good byte available on o_byte_data
//   o_byte_data     received byte (stable while o_byte_valid is high)
//   o_framing_error 1-cycle pulse: stop bit sampled low, byte dropped
//   o_tick          oversample tick (1-cycle pulse)
module uart_rx_core
  import rxd_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sdi,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_framing_error,
  output logic       o_tick
);

  localparam int DIV  = tick_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW   = $clog2(OVERSAMPLE + 2);
  localparam int HALF = OVERSAMPLE / 2;

  // Input synchroniser (idles high so reset does not look like a start bit)
  logic r_sync1, r_sync2;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_sdi;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running tick generator
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  assign w_tick = (r_tick_cnt == TW'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // RX FSM. In START the sample counter counts from the detection tick.
  // From the start-bit mid-sample onward it counts mid-bit to mid-bit, so
  // samples OVERSAMPLE/2-1, /2, /2+1 of a bit land on counts OVERSAMPLE-1,
  // OVERSAMPLE, OVERSAMPLE+1; the bit is resolved at the last one and the
  // counter reloads with 1 (one tick past the new mid-bit).
  rx_state_t   r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [2:0]  r_bit_cnt, w_bit_cnt_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_s0, w_s0_next, r_s1, w_s1_next;
  logic        r_byte_valid, w_byte_valid_next;
  logic        r_fe, w_fe_next;
  logic        w_majority;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_majority = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_byte_valid <= 1'b0;
      r_fe         <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_s0         <= w_s0_next;
      r_s1         <= w_s1_next;
      r_byte_valid <= w_byte_valid_next;
      r_fe         <= w_fe_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_bit_cnt_next    = r_bit_cnt;
    w_shift_next      = r_shift;
    w_s0_next         = r_s0;
    w_s1_next         = r_s1;
    w_byte_valid_next = 1'b0;
    w_fe_next         = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_tick && !r_sync2) begin
          w_state_next = RX_START;
          w_cnt_next   = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (w_cnt_inc == CW'(HALF)) begin
            if (r_sync2) begin
              w_state_next = RX_IDLE;   // glitch, silently ignored
            end else begin
              w_state_next   = RX_DATA;
              w_cnt_next     = '0;
              w_bit_cnt_next = '0;
            end
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CW'(OVERSAMPLE - 1)) w_s0_next = r_sync2;
          if (w_cnt_inc == CW'(OVERSAMPLE))     w_s1_next = r_sync2;
          if (w_cnt_inc == CW'(OVERSAMPLE + 1)) begin
            w_shift_next   = {w_majority, r_shift[7:1]};
            w_cnt_next     = CW'(1);
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) w_state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CW'(OVERSAMPLE)) begin
            if (r_sync2) w_byte_valid_next = 1'b1;
            else         w_fe_next         = 1'b1;
            w_state_next = RX_IDLE;
          end
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  assign o_byte_valid    = r_byte_valid;
  assign o_byte_data     = r_shift;
  assign o_framing_error = r_fe;
  assign o_tick          = w_tick;

endmodule

// File: rtl/rxd_word_assembler.sv
// rxd_word_assembler
//   Receives 8N1 bytes and packs consecutive pairs (first byte high) into a
//   16-bit word, with a per-byte valid/taken handshake.
// Ports
//   i_clk              system clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_sdi              serial data in, idle high
//   o_data             [15:8] first byte of pair, [7:0] second byte
//   o_data_available   [1] high byte valid, [0] low byte valid
//   i_data_taken       per-slot clear of o_data_available
//   o_framing_error    1-cycle pulse: stop bit low
//   o_overrun          1-cycle pulse: byte written into a still-valid slot
//   o_timeout          1-cycle pulse: low byte did not arrive in time
module rxd_word_assembler
  import rxd_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sdi,
  output logic [15:0] o_data,
  output logic [1:0]  o_data_available,
  input  logic [1:0]  i_data_taken,
  output logic        o_framing_error,
  output logic        o_overrun,
  output logic        o_timeout
);

  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TOW      = $clog2(TO_LIMIT + 1);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_fe;
  logic       w_tick;

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_sdi          (i_sdi),
    .o_byte_valid   (w_byte_valid),
    .o_byte_data    (w_byte_data),
    .o_framing_error(w_fe),
    .o_tick         (w_tick)
  );

  // Assembly FSM with the low-byte timeout counter
  asm_state_t     r_asm_state, w_asm_state_next;
  logic [TOW-1:0] r_to_cnt, w_to_cnt_next;
  logic           r_timeout, w_timeout_next;
  logic           r_overrun;
  logic [1:0]     w_wr;   // slot write strobes: [1] high byte, [0] low byte
  logic [1:0]     w_ovr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm_state <= ASM_HI;
      r_to_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_asm_state <= w_asm_state_next;
      r_to_cnt    <= w_to_cnt_next;
      r_timeout   <= w_timeout_next;
      r_overrun   <= |w_ovr;
    end
  end

  always_comb begin
    w_asm_state_next = r_asm_state;
    w_to_cnt_next    = r_to_cnt;
    w_timeout_next   = 1'b0;
    w_wr             = 2'b00;
    case (r_asm_state)
      ASM_HI: begin
        w_to_cnt_next = '0;   // so the timeout window starts fresh in ASM_LO
        if (w_byte_valid) begin
          w_wr[1]          = 1'b1;
          w_asm_state_next = ASM_LO;
        end
      end
      ASM_LO: begin
        if (w_byte_valid) begin
          w_wr[0]          = 1'b1;
          w_asm_state_next = ASM_HI;
        end else if (w_fe) begin
          w_asm_state_next = ASM_HI;   // resynchronise pairing on a bad frame
        end else if (w_tick) begin
          if (r_to_cnt == TOW'(TO_LIMIT - 1)) begin
            w_timeout_next   = 1'b1;
            w_asm_state_next = ASM_HI;
          end else begin
            w_to_cnt_next = r_to_cnt + 1'b1;
          end
        end
      end
      default: w_asm_state_next = ASM_HI;
    endcase
  end

  // Per-slot byte register and valid flag; a write beats a same-cycle take
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [7:0] r_byte;
      logic       r_avail;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_byte  <= '0;
          r_avail <= 1'b0;
        end else if (w_wr[gi]) begin
          r_byte  <= w_byte_data;
          r_avail <= 1'b1;
        end else if (i_data_taken[gi]) begin
          r_avail <= 1'b0;
        end
      end
      assign w_ovr[gi]            = w_wr[gi] & r_avail & ~i_data_taken[gi];
      assign o_data[gi*8 +: 8]    = r_byte;
      assign o_data_available[gi] = r_avail;
    end
  endgenerate

  assign o_framing_error = w_fe;
  assign o_overrun       = r_overrun;
  assign o_timeout       = r_timeout;

endmodule
